// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Optional feature macro used by the top: FETCH_BOUNDS_CHECK_EN.
package fetch_pkg;

  localparam int          INSTR_W              = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'd40;
  localparam int          DEFAULT_MEM_WORDS    = 250;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  // Redirect targets are word-aligned by dropping the low bits; no trap.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: hold, sequential PC+4 (modulo 2^32), or
// word-aligned redirect target.
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic    [31:0] pc,
  input  pc_sel_e        sel,
  input  logic    [31:0] redirect_target,
  output logic    [31:0] pc_next,
  output logic    [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_next = pc;
    unique case (sel)
      PC_INC:      pc_next = pc_plus4;
      PC_REDIRECT: pc_next = align_word(redirect_target);
      default:     pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, captures the IF/ID register and
// handles stall, redirect/flush and halt. Optional macro: FETCH_BOUNDS_CHECK_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          MEM_WORDS    = DEFAULT_MEM_WORDS
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               halted,
  output logic               fault
);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [31:0]        if_id_pc4_q, if_id_pc4_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  pc_sel_e            pc_sel;
  logic [31:0]        pc_plus4;
  logic               bounds_hit;

  fetch_pc_next u_pc_next (
    .pc              (pc_q),
    .sel             (pc_sel),
    .redirect_target (redirect_target),
    .pc_next         (pc_d),
    .pc_plus4        (pc_plus4)
  );

  // Folds to constant 0 when the bounds check is compiled out.
  assign bounds_hit = BOUNDS_EN && (pc_q[31:2] >= MEM_WORDS_W);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case tree can leave a variable unassigned and infer a latch.
    state_d       = state_q;
    pc_sel        = PC_HOLD;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    halted_d      = halted_q;
    fault_d       = fault_q;

    unique case (state_q)
      FS_BOOT: begin
        state_d       = FS_RUN;
        if_id_valid_d = 1'b0;
      end

      FS_RUN: begin
        if (halt_req) begin
          state_d       = FS_HALT;
          halted_d      = 1'b1;
          if_id_valid_d = 1'b0;
        end else if (redirect_valid) begin
          // The word on instr_data this cycle is wrong-path; flush it.
          pc_sel        = PC_REDIRECT;
          if_id_instr_d = '0;
          if_id_valid_d = 1'b0;
        end else if (stall) begin
          pc_sel = PC_HOLD;
        end else if (bounds_hit) begin
          state_d       = FS_HALT;
          halted_d      = 1'b1;
          fault_d       = 1'b1;
          if_id_valid_d = 1'b0;
        end else begin
          pc_sel        = PC_INC;
          if_id_instr_d = instr_data;
          if_id_pc4_d   = pc_plus4;
          if_id_valid_d = 1'b1;
        end
      end

      FS_HALT: begin
        halted_d      = 1'b1;
        if_id_valid_d = 1'b0;
      end

      default: begin
        state_d       = FS_BOOT;
        if_id_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FS_BOOT;
      pc_q          <= RESET_VECTOR;
      if_id_instr_q <= '0;
      if_id_pc4_q   <= '0;
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  assign instr_addr  = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = halted_q;
  assign fault       = BOUNDS_EN ? fault_q : 1'b0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for the main fetch stream
// plus hand-written reset, halt and bounds sequences.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [250];

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .instr_addr      (instr_addr),
    .instr_data      (instr_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .halted          (halted),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (idx < 32'd250) return mem[idx[7:0]];
    return 32'hBAD0_0000 | {16'h0000, addr[15:0]};
  endfunction

  assign instr_data = mem_word(instr_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    halt_req        = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".addr"},  instr_addr,  32'd40);
    check({tag, ".instr"}, if_id_instr, 32'h0);
    check({tag, ".pc4"},   if_id_pc4,   32'h0);
    check({tag, ".valid"}, {31'h0, if_id_valid}, 32'h0);
    check({tag, ".halted"},{31'h0, halted}, 32'h0);
    check({tag, ".fault"}, {31'h0, fault},  32'h0);
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic        halt;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic        chk_instr;
    logic [31:0] e_pc4;
    logic        chk_pc4;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  initial begin
    for (int i = 0; i < 250; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[10] = 32'h2008_0002;
    mem[11] = 32'hAC85_0000;
    mem[12] = 32'h8C86_0000;

    // stall redir target halt | addr instr chk pc4 chk valid halted
    vecs[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'd40,  32'h0,         1'b1, 32'd0,  1'b1, 1'b0, 1'b0}; // BOOT
    vecs[1] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'd44,  32'h2008_0002, 1'b1, 32'd44, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'd44,  32'h2008_0002, 1'b1, 32'd44, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'd44,  32'h2008_0002, 1'b1, 32'd44, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'd48,  32'hAC85_0000, 1'b1, 32'd48, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h3E, 1'b0, 32'h3C,  32'h0,         1'b1, 32'd0,  1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h40,  32'h1000_000F, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h44,  32'h1000_0010, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 32'h80, 1'b1, 32'h44,  32'h0,         1'b0, 32'd0,  1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    clear_inputs();
    step();
    step();
    check_reset_state("reset");

    reset = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      stall           = vecs[i].stall;
      redirect_valid  = vecs[i].redir;
      redirect_target = vecs[i].target;
      halt_req        = vecs[i].halt;
      step();
      check($sformatf("vec%0d.addr", i), instr_addr, vecs[i].e_addr);
      if (vecs[i].chk_instr) check($sformatf("vec%0d.instr", i), if_id_instr, vecs[i].e_instr);
      if (vecs[i].chk_pc4)   check($sformatf("vec%0d.pc4", i), if_id_pc4, vecs[i].e_pc4);
      check($sformatf("vec%0d.valid", i),  {31'h0, if_id_valid}, {31'h0, vecs[i].e_valid});
      check($sformatf("vec%0d.halted", i), {31'h0, halted},      {31'h0, vecs[i].e_halted});
      check($sformatf("vec%0d.fault", i),  {31'h0, fault},       32'h0);
    end

    // HALT ignores every input except reset.
    for (int k = 0; k < 10; k++) begin
      stall           = 1'($urandom_range(1));
      halt_req        = 1'($urandom_range(1));
      redirect_valid  = 1'b1;
      redirect_target = 32'h200;
      step();
      check($sformatf("halt%0d.addr", k),   instr_addr, 32'h44);
      check($sformatf("halt%0d.valid", k),  {31'h0, if_id_valid}, 32'h0);
      check($sformatf("halt%0d.halted", k), {31'h0, halted}, 32'h1);
    end

    clear_inputs();
    reset = 1'b1;
    step();
    check_reset_state("halt_reset");

    // BOOT cycle ignores halt, redirect and stall.
    reset           = 1'b0;
    halt_req        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    stall           = 1'b1;
    step();
    check("boot.addr",   instr_addr, 32'd40);
    check("boot.valid",  {31'h0, if_id_valid}, 32'h0);
    check("boot.halted", {31'h0, halted}, 32'h0);
    clear_inputs();
    step();
    check("run1.addr",  instr_addr,  32'd44);
    check("run1.instr", if_id_instr, 32'h2008_0002);
    check("run1.valid", {31'h0, if_id_valid}, 32'h1);
    step();
    check("run2.addr",  instr_addr,  32'd48);
    check("run2.instr", if_id_instr, 32'hAC85_0000);
    check("run2.pc4",   if_id_pc4,   32'd48);

    // Reset mid-stream at PC = 48 with a valid IF/ID word.
    reset = 1'b1;
    step();
    check_reset_state("mid_reset");
    reset = 1'b0;
    step();
    check("mid_boot.addr",  instr_addr, 32'd40);
    check("mid_boot.valid", {31'h0, if_id_valid}, 32'h0);
    step();
    check("mid_run.addr",  instr_addr, 32'd44);
    check("mid_run.valid", {31'h0, if_id_valid}, 32'h1);

    // Redirect to word 250 (byte 1000), then fetch it.
    redirect_valid  = 1'b1;
    redirect_target = 32'd1000;
    step();
    check("oob_redir.addr",  instr_addr, 32'd1000);
    check("oob_redir.valid", {31'h0, if_id_valid}, 32'h0);
    check("oob_redir.fault", {31'h0, fault}, 32'h0);
    clear_inputs();
    step();
`ifdef FETCH_BOUNDS_CHECK_EN
    check("oob.fault",  {31'h0, fault},  32'h1);
    check("oob.halted", {31'h0, halted}, 32'h1);
    check("oob.valid",  {31'h0, if_id_valid}, 32'h0);
    check("oob.addr",   instr_addr, 32'd1000);
    redirect_valid  = 1'b1;
    redirect_target = 32'd40;
    step();
    clear_inputs();
    check("oob_sticky.fault", {31'h0, fault}, 32'h1);
    check("oob_sticky.addr",  instr_addr, 32'd1000);
`else
    check("oob.fault", {31'h0, fault}, 32'h0);
    check("oob.valid", {31'h0, if_id_valid}, 32'h1);
    check("oob.pc4",   if_id_pc4,   32'd1004);
    check("oob.instr", if_id_instr, 32'hBAD0_03E8);
    check("oob.addr",  instr_addr,  32'd1004);

    // PC + 4 wraps modulo 2^32 with no flag.
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    check("wrap_redir.addr", instr_addr, 32'hFFFF_FFFC);
    step();
    check("wrap.addr",  instr_addr, 32'h0);
    check("wrap.pc4",   if_id_pc4,  32'h0);
    check("wrap.instr", if_id_instr, 32'hBAD0_FFFC);
    check("wrap.fault", {31'h0, fault}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
